// File: rtl/sa_params_pkg.sv
// Shared AXI parameters and the address-generator state type.
package sa_params_pkg;

    localparam int unsigned AXI_ADDR_WIDTH      = 32;
    localparam int unsigned AXI_DATA_WIDTH      = 32;
    localparam int unsigned AXI_MAX_BURST_BEATS = 16;
    localparam int unsigned AXI_4KB_BOUNDARY    = 4096;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ISSUE,
        DONE
    } ag_state_e;

endpackage

// File: rtl/axi_addr_gen.sv
// Splits a byte region into AXI INCR burst requests that never cross 4 KB
// and never exceed MAX_BEATS beats; one request in flight at a time.
module axi_addr_gen
    import sa_params_pkg::*;
#(
    parameter int unsigned ADDR_W    = AXI_ADDR_WIDTH,
    parameter int unsigned DATA_W    = AXI_DATA_WIDTH,
    parameter int unsigned MAX_BEATS = AXI_MAX_BURST_BEATS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       bytes_total,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic [7:0]        req_len,
    output logic              req_last,
    output logic              done,
    output logic              busy
);

    localparam int unsigned BPB      = DATA_W / 8;
    localparam int unsigned ADDR_LSB = $clog2(BPB);
    localparam int unsigned BND_W    = 13 - ADDR_LSB;
    localparam int unsigned BEATS_W  = 9;
    localparam int unsigned REM_W    = 31;

    ag_state_e           state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [BEATS_W-1:0]  beats_q, beats_d;
    logic                req_valid_q, req_valid_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [7:0]          req_len_q, req_len_d;
    logic                req_last_q, req_last_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic [12:0]         span_c;
    logic [BND_W-1:0]    bnd_c;
    logic [REM_W-1:0]    min_c;
    logic [BEATS_W-1:0]  beats_c;

    // Burst length: min(remaining, MAX_BEATS, beats left before the 4 KB line)
    always_comb begin
        span_c = 13'(AXI_4KB_BOUNDARY) - {1'b0, cur_addr_q[11:0]};
        bnd_c  = BND_W'(span_c >> ADDR_LSB);
        min_c  = REM_W'(MAX_BEATS);
        if (REM_W'(bnd_c) < min_c) begin
            min_c = REM_W'(bnd_c);
        end
        if (rem_q < min_c) begin
            min_c = rem_q;
        end
        beats_c = BEATS_W'(min_c);
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        rem_d       = rem_q;
        beats_d     = beats_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_len_d   = req_len_q;
        req_last_d  = req_last_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // done_q marks the DONE->IDLE cycle; a start there is dropped
                if (start && !done_q) begin
                    cur_addr_d = base_addr & ~ADDR_W'(BPB - 1);
                    rem_d      = REM_W'((33'(bytes_total) + 33'(BPB - 1)) >> ADDR_LSB);
                    state_d    = CALC;
                end
            end
            CALC: begin
                if (rem_q == '0) begin
                    state_d = DONE;
                end else begin
                    beats_d     = beats_c;
                    req_addr_d  = cur_addr_q;
                    req_len_d   = 8'(beats_c - BEATS_W'(1));
                    req_last_d  = (REM_W'(beats_c) == rem_q);
                    req_valid_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (req_ready) begin
                    cur_addr_d  = cur_addr_q + (ADDR_W'(beats_q) << ADDR_LSB);
                    rem_d       = rem_q - REM_W'(beats_q);
                    req_valid_d = 1'b0;
                    state_d     = req_last_q ? DONE : CALC;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            rem_q       <= '0;
            beats_q     <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_len_q   <= '0;
            req_last_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            rem_q       <= rem_d;
            beats_q     <= beats_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_len_q   <= req_len_d;
            req_last_q  <= req_last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign req_valid = req_valid_q;
    assign req_addr  = req_addr_q;
    assign req_len   = req_len_q;
    assign req_last  = req_last_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_axi_addr_gen.sv
// Directed bench for axi_addr_gen: a region-splitting model feeds a request
// scoreboard; a monitor checks handshakes, stability, gaps and reset values.
module tb_axi_addr_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] bytes_total;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic        req_last;
    logic        done;
    logic        busy;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   total    = 0;
    int   bad      = 0;
    int   done_cnt = 0;

    axi_addr_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .bytes_total(bytes_total),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_last   (req_last),
        .done       (done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference split: walk the region in 4-byte beats, cutting at 16 beats or 4 KB
    task automatic build_expect(input logic [31:0] b, input logic [31:0] n);
        longint unsigned a, rem, bb, lim;
        exp_t e;
        a   = 64'(b & 32'hFFFF_FFFC);
        rem = (64'(n) + 64'd3) / 64'd4;
        while (rem != 0) begin
            bb = rem;
            if (bb > 16) bb = 16;
            lim = (64'd4096 - (a % 64'd4096)) / 64'd4;
            if (bb > lim) bb = lim;
            e.addr = 32'(a);
            e.len  = 8'(bb - 1);
            e.last = (bb == rem);
            exp_q.push_back(e);
            a   = (a + 64'd4 * bb) % 64'h1_0000_0000;
            rem = rem - bb;
        end
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [31:0] n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; bytes_total = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int d0);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("done_seen", 64'(seen), 64'd1);
        @(negedge clk);
        chk("done_width", 64'(done), 64'd0);
        chk("done_count", 64'(done_cnt - d0), 64'd1);
        chk("exp_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_region(input logic [31:0] b, input logic [31:0] n);
        int d0;
        build_expect(b, n);
        d0 = done_cnt;
        pulse_start(b, n);
        wait_done(400, d0);
    endtask

    // Monitor: reset values, scoreboard on handshake, hold stability, 1-cycle gap
    initial begin
        logic        pv, pr, plast, hs_last;
        logic [31:0] paddr;
        logic [7:0]  plen;
        int          pend;
        exp_t        e;
        pv = 1'b0; pr = 1'b0; plast = 1'b0; paddr = '0; plen = '0;
        pend = 0; hs_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_outs", 64'({req_valid, req_addr, req_len, req_last, done, busy}), 64'd0);
                pend = 0;
                pv   = 1'b0;
            end else begin
                if (pend == 2) begin
                    chk("gap_low", 64'(req_valid), 64'd0);
                    pend = hs_last ? 0 : 1;
                end else if (pend == 1) begin
                    chk("gap_next_valid", 64'(req_valid), 64'd1);
                    pend = 0;
                end
                if (req_valid && pv && !pr) begin
                    chk("hold_stable", 64'({req_addr, req_len, req_last}), 64'({paddr, plen, plast}));
                end
                if (req_valid && req_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_req", 64'({req_addr, req_len, req_last}), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("req_addr", 64'(req_addr), 64'(e.addr));
                        chk("req_len", 64'(req_len), 64'(e.len));
                        chk("req_last", 64'(req_last), 64'(e.last));
                    end
                    pend    = 2;
                    hs_last = req_last;
                end
                if (done) done_cnt++;
                pv = req_valid; pr = req_ready;
                paddr = req_addr; plen = req_len; plast = req_last;
            end
        end
    end

    initial begin
        int  d0;
        bit  seen;
        rst = 1'b1; start = 1'b0; base_addr = '0; bytes_total = '0; req_ready = 1'b1;

        // Pin the model against hand-split regions
        build_expect(32'h0, 32'd200);
        chk("pin200_n", 64'(exp_q.size()), 64'd4);
        chk("pin200_1", 64'({exp_q[1].addr, exp_q[1].len, exp_q[1].last}), 64'({32'h40, 8'd15, 1'b0}));
        chk("pin200_3", 64'({exp_q[3].addr, exp_q[3].len, exp_q[3].last}), 64'({32'hC0, 8'd1, 1'b1}));
        exp_q.delete();
        build_expect(32'h0FF0, 32'd64);
        chk("pinff0_0", 64'({exp_q[0].addr, exp_q[0].len, exp_q[0].last}), 64'({32'h0FF0, 8'd3, 1'b0}));
        chk("pinff0_1", 64'({exp_q[1].addr, exp_q[1].len, exp_q[1].last}), 64'({32'h1000, 8'd11, 1'b1}));
        exp_q.delete();
        build_expect(32'h2002, 32'd6);
        chk("pin2002", 64'({exp_q[0].addr, exp_q[0].len, exp_q[0].last}), 64'({32'h2000, 8'd1, 1'b1}));
        exp_q.delete();

        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // Single burst with exact cycle timing, then a start coinciding with done
        build_expect(32'h1000, 32'd64);
        pulse_start(32'h1000, 32'd64);
        @(negedge clk); chk("t1_valid_n1", 64'(req_valid), 64'd0);
        @(negedge clk); chk("t1_valid_n2", 64'(req_valid), 64'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        @(negedge clk); chk("t1_done_n3", 64'(done), 64'd0);
        @(negedge clk); chk("t1_done_n4", 64'(done), 64'd1);
        #1 start = 1'b1; base_addr = 32'h5000; bytes_total = 32'd16;
        @(posedge clk); #1 start = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (req_valid || busy || done) seen = 1'b1;
        end
        chk("start_at_done_ignored", 64'(seen), 64'd0);
        chk("t1_exp_left", 64'(exp_q.size()), 64'd0);

        run_region(32'h0, 32'd200);
        run_region(32'h0FF0, 32'd64);
        run_region(32'h2002, 32'd6);
        run_region(32'h0000_FFC0, 32'd1024);
        run_region(32'hFFFF_FFF8, 32'd16);

        // Empty region: done three cycles after start, no request
        d0 = done_cnt;
        pulse_start(32'h500, 32'd0);
        @(negedge clk); chk("z_done_n1", 64'({done, req_valid}), 64'd0);
        @(negedge clk); chk("z_done_n2", 64'({done, req_valid}), 64'd0);
        @(negedge clk); chk("z_done_n3", 64'({done, req_valid}), 64'b10);
        @(negedge clk); chk("z_done_n4", 64'(done), 64'd0);
        chk("z_done_count", 64'(done_cnt - d0), 64'd1);

        // Back-pressure with stray starts while busy
        @(posedge clk); #1 req_ready = 1'b0;
        build_expect(32'h0, 32'd200);
        d0 = done_cnt;
        pulse_start(32'h0, 32'd200);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (req_valid) seen = 1'b1;
        end
        chk("stall_valid_seen", 64'(seen), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            start = (i % 2 == 0); base_addr = 32'h3000; bytes_total = 32'd4;
            @(negedge clk);
            chk("stall_hold_valid", 64'(req_valid), 64'd1);
        end
        @(posedge clk); #1 start = 1'b0; req_ready = 1'b1;
        wait_done(400, d0);
        repeat (4) @(negedge clk);
        chk("stall_idle", 64'({busy, req_valid}), 64'd0);

        // Reset during the second burst abandons the region
        build_expect(32'h0, 32'd200);
        pulse_start(32'h0, 32'd200);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (req_valid && req_addr == 32'h40) seen = 1'b1;
        end
        chk("rst_second_burst_seen", 64'(seen), 64'd1);
        #1 rst = 1'b1;
        exp_q.delete();
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
        chk("rst_idle", 64'({busy, req_valid}), 64'd0);
        run_region(32'h0, 32'd64);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_addr_gen.md
AXI_ADDR_GEN -- requirements
Module: axi_addr_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_W, AXI_ADDR_WIDTH, byte address width; DATA_W, AXI_DATA_WIDTH, beat width (32b, 4 bytes/beat); MAX_BEATS, AXI_MAX_BURST_BEATS (16), max beats per burst (1..256).
REQ-002 SHALL have ports (name, direction, width, meaning) as REQ-003 to REQ-013, in that order; one clock; reset asynchronous, active-high.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 start  in  1  one-cycle pulse, begin a region.
REQ-006 base_addr  in  ADDR_W  region start byte address.
REQ-007 bytes_total  in  32  region length in bytes.
REQ-008 req_valid  out  1  burst request valid.
REQ-009 req_ready  in  1  consumer accepts the request this cycle.
REQ-010 req_addr  out  ADDR_W  burst start byte address.
REQ-011 req_len  out  8  AXI len, equal to beats-1.
REQ-012 req_last  out  1  final burst of the region.
REQ-013 done / busy  out  1 each  done: one-cycle pulse, region complete; busy: high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, ISSUE, DONE.
REQ-015 IDLE: on start, latch cur_addr = base_addr with bits [1:0] forced to 0, latch rem_beats = ceil(bytes_total/4), then go to CALC; start SHALL be ignored in all other states.
REQ-016 CALC: if rem_beats==0, go to DONE; otherwise register beats = min(rem_beats, MAX_BEATS, (4096 - cur_addr[11:0])>>2), drive req_addr=cur_addr, req_len=beats-1, req_last=(beats==rem_beats), and go to ISSUE.
REQ-017 ISSUE: hold req_valid=1 with req_addr, req_len and req_last stable until the cycle in which req_valid&&req_ready is true.
REQ-018 On that handshake: cur_addr += beats*4, rem_beats -= beats, drop req_valid next cycle, go to DONE if req_last else to CALC.
REQ-019 Latency: req_valid SHALL assert 2 cycles after start; there is exactly 1 idle cycle between a handshake and the next req_valid.
REQ-020 DONE: assert done for exactly one cycle, then return to IDLE; for a region with bytes_total==0, done SHALL assert 3 cycles after start with no request issued.
REQ-021 No burst SHALL cross a 4 KB address boundary; burst beat counts SHALL never exceed MAX_BEATS.
REQ-022 Arithmetic: rem_beats 31 bits; the beats-to-boundary term is computed in 11 bits (range 1..1024); cur_addr wraps modulo 2^ADDR_W.
REQ-023 A start pulse arriving in the same cycle as done SHALL be ignored.
REQ-024 req_ready while req_valid is low SHALL have no effect.

Reset
REQ-025 While rst is high: state=IDLE, and req_valid, req_addr, req_len, req_last, done and busy are all 0, along with all internal counters.
REQ-026 A reset asserted mid-region SHALL abandon the region, with no done pulse; the first start after reset deassertion SHALL behave as from power-up.

Structure
REQ-027 sa_params_pkg SHALL hold AXI_MAX_BURST_BEATS=16, AXI_4KB_BOUNDARY=4096 and typedef ag_state_e {IDLE, CALC, ISSUE, DONE}; AXI_ADDR_WIDTH and AXI_DATA_WIDTH are reused from it.
REQ-028 The block SHALL be a single module with no sub-module; the burst-length min() is inline combinational logic feeding the CALC registers.

Verification
REQ-029 start, base 0x1000, bytes 64, req_ready=1 -> one request: addr 0x1000, len 15, last=1; done 2 cycles after the handshake.
REQ-030 base 0x0, bytes 200 -> four requests: (0x000, 15), (0x040, 15), (0x080, 15), (0x0C0, 1); last=1 only on the 4th; one done pulse.
REQ-031 base 0x0FF0, bytes 64 -> two requests: (0x0FF0, len 3), then (0x1000, len 11, last=1); bytes 6 at base 0x2002 -> single request (0x2000, len 1).
REQ-032 bytes_total 0 -> req_valid never asserts; done pulses once 3 cycles after start.
REQ-033 req_ready held low 5 cycles in ISSUE, plus start pulses during busy -> req_valid and fields stable throughout; extra starts ignored; request sequence unchanged.
REQ-034 rst asserted during the 2nd burst of the 200-byte case -> all outputs 0 while reset is high, no done pulse; a new start of 64 bytes at 0x0 -> single request (0x0, 15).
